// File: rtl/led_status_ctl_pkg.sv
// Shared LED mode encoding for the status controller and its channels.
// Encoding values are the ones the CSR side writes on wr_mode.
package led_status_ctl_pkg;

  localparam int LED_MODE_W = 2;

  typedef enum logic [LED_MODE_W-1:0] {
    LED_MODE_OFF   = 2'd0,
    LED_MODE_ON    = 2'd1,
    LED_MODE_BLINK = 2'd2,
    LED_MODE_FLASH = 2'd3
  } led_mode_e;

  function automatic logic mode_lit(input led_mode_e m);
    return (m != LED_MODE_OFF);
  endfunction

endpackage

// File: rtl/led_status_chan.sv
// One LED channel: mode/half registers, tick phase counter, LED drive and
// the one-cycle flash completion pulse.
module led_status_chan
  import led_status_ctl_pkg::*;
#(
  parameter int HALF_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_wr,
  input  led_mode_e         i_mode,
  input  logic [HALF_W-1:0] i_half,
  input  logic              i_tick,
  output logic              o_led,
  output logic              o_done
);

  led_mode_e         r_mode;
  logic [HALF_W-1:0] r_half;
  logic [HALF_W-1:0] r_phase;
  logic              r_led;
  logic              r_done;
  logic              w_last;

  // r_half is stored already normalised (never 0), so half-1 cannot wrap
  assign w_last = (r_phase == (r_half - 1'b1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mode  <= LED_MODE_OFF;
      r_half  <= {{(HALF_W-1){1'b0}}, 1'b1};
      r_phase <= '0;
      r_led   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_wr) begin
        r_mode  <= i_mode;
        r_half  <= (i_half == '0) ? {{(HALF_W-1){1'b0}}, 1'b1} : i_half;
        r_phase <= '0;
        r_led   <= mode_lit(i_mode);
      end else if (i_tick) begin
        case (r_mode)
          LED_MODE_BLINK: begin
            if (w_last) begin
              r_led   <= ~r_led;
              r_phase <= '0;
            end else begin
              r_phase <= r_phase + 1'b1;
            end
          end
          LED_MODE_FLASH: begin
            if (w_last) begin
              r_led   <= 1'b0;
              r_mode  <= LED_MODE_OFF;
              r_phase <= '0;
              r_done  <= 1'b1;
            end else begin
              r_phase <= r_phase + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign o_led  = r_led;
  assign o_done = r_done;

endmodule

// File: rtl/led_status_ctl.sv
// Multi-channel LED status driver: shared tick prescaler plus write decode
// feeding N_LED independent channels.
module led_status_ctl
  import led_status_ctl_pkg::*;
#(
  parameter int CLK_HZ  = 25_000_000,
  parameter int TICK_HZ = 1000,
  parameter int N_LED   = 4,
  parameter int HALF_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [3:0]            wr_ch,
  input  logic [LED_MODE_W-1:0] wr_mode,
  input  logic [HALF_W-1:0]     wr_half,
  output logic [N_LED-1:0]      led_o,
  output logic [N_LED-1:0]      flash_done,
  output logic                  tick_o
);

  localparam int              PRESCALE = CLK_HZ / TICK_HZ;
  localparam int              PS_W     = $clog2(PRESCALE);
  localparam logic [PS_W-1:0] PS_MAX   = PS_W'(PRESCALE - 1);
  localparam logic [4:0]      N_LED_L  = 5'(N_LED);

  logic [PS_W-1:0]  r_cnt;
  logic             r_tick;
  logic             w_ch_ok;
  logic [N_LED-1:0] w_wr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_cnt  <= (r_cnt == PS_MAX) ? '0 : r_cnt + 1'b1;
      r_tick <= (r_cnt == PS_MAX);
    end
  end

  assign tick_o  = r_tick;
  // out-of-range channel writes are dropped entirely
  assign w_ch_ok = ({1'b0, wr_ch} < N_LED_L);

  for (genvar g = 0; g < N_LED; g++) begin : g_ch
    assign w_wr[g] = wr_en && w_ch_ok && (wr_ch == 4'(g));

    led_status_chan #(.HALF_W(HALF_W)) u_chan (
      .clk    (clk),
      .rst    (rst),
      .i_wr   (w_wr[g]),
      .i_mode (led_mode_e'(wr_mode)),
      .i_half (wr_half),
      .i_tick (r_tick),
      .o_led  (led_o[g]),
      .o_done (flash_done[g])
    );
  end

endmodule

// File: tb/tb_led_status_ctl.sv
// Bench for led_status_ctl: directed scenarios plus random writes, checked
// every cycle against a tick-count model of each channel.
module tb_led_status_ctl;

  localparam int N = 4;
  localparam int P = 10;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en;
  logic [3:0] wr_ch;
  logic [1:0] wr_mode;
  logic [7:0] wr_half;
  logic [N-1:0] led_o, flash_done;
  logic       tick_o;

  led_status_ctl #(.CLK_HZ(100), .TICK_HZ(10), .N_LED(N), .HALF_W(8)) dut (
    .clk(clk), .rst(rst_n), .wr_en(wr_en), .wr_ch(wr_ch), .wr_mode(wr_mode),
    .wr_half(wr_half), .led_o(led_o), .flash_done(flash_done), .tick_o(tick_o)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // model: per channel, mode, effective half and ticks seen since last write
  int         m_mode [N];
  int         m_half [N];
  int         m_ticks[N];
  logic [N-1:0] m_led, m_done;
  logic       m_tick;
  int         cyc;
  int         done_cnt[N];
  int         first_tick;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < N; c++) begin
      m_mode[c] = 0; m_half[c] = 1; m_ticks[c] = 0;
    end
    m_led = '0; m_done = '0; m_tick = 1'b0; cyc = 0;
  endtask

  task automatic model_edge();
    logic t;
    t = m_tick;
    m_done = '0;
    for (int c = 0; c < N; c++) begin
      if (wr_en && (int'(wr_ch) == c)) begin
        m_mode[c]  = int'(wr_mode);
        m_half[c]  = (wr_half == 0) ? 1 : int'(wr_half);
        m_ticks[c] = 0;
        m_led[c]   = (wr_mode != 2'd0);
      end else if (t) begin
        if (m_mode[c] == 2) begin
          m_ticks[c]++;
          m_led[c] = ((m_ticks[c] / m_half[c]) % 2 == 0);
        end else if (m_mode[c] == 3) begin
          m_ticks[c]++;
          if (m_ticks[c] == m_half[c]) begin
            m_led[c] = 1'b0; m_mode[c] = 0; m_done[c] = 1'b1;
          end
        end
      end
    end
    m_tick = ((cyc + 1) % P == 0);
    cyc++;
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_edge();
    #1;
    chk("led_o", 32'(led_o), 32'(m_led));
    chk("flash_done", 32'(flash_done), 32'(m_done));
    chk("tick_o", 32'(tick_o), 32'(m_tick));
    for (int c = 0; c < N; c++) done_cnt[c] += int'(flash_done[c]);
  endtask

  task automatic wr(input int ch, input int mode, input int half);
    wr_en = 1'b1; wr_ch = 4'(ch); wr_mode = 2'(mode); wr_half = 8'(half);
    step();
    wr_en = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int found;
    wr_en = 1'b0; wr_ch = '0; wr_mode = '0; wr_half = '0;
    for (int c = 0; c < N; c++) done_cnt[c] = 0;
    rst_n = 1'b0;
    model_reset();
    run(5);
    chk("reset_led", 32'(led_o), 0);
    #2 rst_n = 1'b1;

    // first tick must land on edge 10 after release
    first_tick = 0;
    for (int i = 1; i <= 12; i++) begin
      step();
      if (tick_o && first_tick == 0) first_tick = i;
    end
    chk("first_tick_edge", 32'(first_tick), 10);

    // BLINK ch0 half=3
    wr(0, 2, 3);
    chk("blink_lit_after_wr", 32'(led_o[0]), 1);
    run(100);
    chk("others_dark", 32'(led_o[3:1]), 0);

    // FLASH ch2 half=2: exactly one done pulse
    done_cnt[2] = 0;
    wr(2, 3, 2);
    run(40);
    chk("flash_pulses", 32'(done_cnt[2]), 1);
    chk("flash_led_off", 32'(led_o[2]), 0);

    // write ch1 ON on a tick cycle while ch0 blinks
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      if (tick_o) found = 1;
      else step();
    end
    chk("tick_wait", 32'(found), 1);
    wr(1, 1, 0);
    chk("on_same_tick", 32'(led_o[1]), 1);
    run(25);

    // abort FLASH ch2 with OFF mid-flight: no pulse
    done_cnt[2] = 0;
    wr(2, 3, 5);
    run(25);
    wr(2, 0, 0);
    chk("abort_led_off", 32'(led_o[2]), 0);
    run(60);
    chk("abort_no_pulse", 32'(done_cnt[2]), 0);

    // out-of-range channel write
    wr(7, 1, 1);
    run(10);

    // BLINK half=0 behaves as half=1
    wr(3, 2, 0);
    run(45);

    // random writes, including out-of-range channels
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(7) == 0) begin
        wr_en = 1'b1; wr_ch = 4'($urandom_range(7));
        wr_mode = 2'($urandom_range(3)); wr_half = 8'($urandom_range(4));
      end else begin
        wr_en = 1'b0;
      end
      step();
    end
    wr_en = 1'b0;

    // async reset mid-blink: outputs clear before the next edge
    wr(0, 2, 1);
    wr(1, 1, 0);
    run(3);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("async_led", 32'(led_o), 0);
    chk("async_done", 32'(flash_done), 0);
    chk("async_tick", 32'(tick_o), 0);
    run(3);
    #2 rst_n = 1'b1;
    run(30);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
